// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: one full-adder slice (two half adders
// plus an OR) stepped over WIDTH clocks, LSB first, with registered flags.
module serial_add_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             ovf
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_next;
    logic [WIDTH-1:0]   sa, sb, rsh;
    logic               carry;
    logic [CNT_W-1:0]   cnt;

    logic hs0, hc0, s, hc1, carry_next, last;

    // Slice: first half adder on the operand bits, second adds the carry.
    assign hs0        = sa[0] ^ sb[0];
    assign hc0        = sa[0] & sb[0];
    assign s          = hs0 ^ carry;
    assign hc1        = hs0 & carry;
    assign carry_next = hc0 | hc1;
    assign last       = (cnt == CNT_W'(WIDTH - 1));

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: state_next = start ? RUN : IDLE;
            RUN:        if (last) state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            sa     <= '0;
            sb     <= '0;
            rsh    <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            result <= '0;
            c_out  <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        sa    <= a;
                        sb    <= sub ? ~b : b;
                        carry <= sub;
                        cnt   <= '0;
                        rsh   <= '0;
                    end
                end
                RUN: begin
                    sa    <= sa >> 1;
                    sb    <= sb >> 1;
                    rsh   <= {s, rsh[WIDTH-1:1]};
                    carry <= carry_next;
                    cnt   <= cnt + CNT_W'(1);
                    // Final slice is the MSB: publish the word and both flags.
                    if (last) begin
                        result <= {s, rsh[WIDTH-1:1]};
                        c_out  <= carry_next;
                        ovf    <= carry ^ carry_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8): directed table,
// multi-cycle corner sequences and a randomized back-to-back sweep.
module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, start, sub;
    logic [7:0] a, b;
    logic       busy, done, c_out, ovf;
    logic [7:0] result;

    int unsigned checks = 0;
    int unsigned errors = 0;

    serial_add_ctrl #(.WIDTH(8), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .c_out(c_out), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic [7:0] r;
        logic       c;
        logic       v;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain WIDTH-bit arithmetic, overflow from operand/result signs.
    function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y, input logic s);
        logic [8:0] full;
        logic [7:0] r;
        logic       v;
        if (s) full = {1'b0, x} + {1'b0, ~y} + 9'd1;
        else   full = {1'b0, x} + {1'b0, y};
        r = full[7:0];
        if (s) v = (x[7] != y[7]) && (r[7] != x[7]);
        else   v = (x[7] == y[7]) && (r[7] != x[7]);
        return {full[8], v, r};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int max, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!done && n < max);
    endtask

    // Entered one step after an edge with the DUT idle; leaves it idle.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic ts,
                          output logic [9:0] got);
        int bad;
        a = ta; b = tb; sub = ts; start = 1'b1;
        tick();
        start = 1'b0;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (busy !== 1'b1 || done !== 1'b0) bad++;
            tick();
        end
        check("busy_window", bad, 0);
        check("done_pulse", {busy, done}, 2'b01);
        got = {c_out, ovf, result};
        tick();
        check("done_one_cycle", done, 1'b0);
    endtask

    vec_t       vecs[6];
    logic [9:0] got, exp;
    int         n;

    initial begin
        vecs[0] = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{8'h10, 8'h01, 1'b1, 8'h0F, 1'b1, 1'b0};
        vecs[4] = '{8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[5] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};

        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        repeat (3) tick();
        check("reset_outputs", {busy, done, c_out, ovf, result}, 12'h000);
        rst_n = 1'b1;
        tick();

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].sub, got);
            check($sformatf("vec%0d", i), got, {vecs[i].c, vecs[i].v, vecs[i].r});
        end

        // Start while busy must be ignored, operands not resampled.
        a = 8'h01; b = 8'h02; sub = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        a = 8'h55; b = 8'h55; start = 1'b1;
        tick();
        start = 1'b0; a = '0; b = '0;
        wait_done(20, n);
        check("ignore_latency", n, 5);
        check("ignore_result", {done, c_out, ovf, result}, {1'b1, 10'h003});
        tick();

        // Start held high: operations chain with a done every 9 cycles.
        begin
            int t[$];
            a = 8'h11; b = 8'h22; sub = 1'b0; start = 1'b1;
            for (int c = 0; c < 40 && t.size() < 3; c++) begin
                tick();
                if (done) begin
                    t.push_back(c);
                    check("chain_result", {c_out, ovf, result}, 10'h033);
                    if (t.size() == 3) start = 1'b0;
                end
            end
            start = 1'b0;
            check("chain_pulses", t.size(), 3);
            if (t.size() == 3) begin
                check("chain_period1", t[1] - t[0], 9);
                check("chain_period2", t[2] - t[1], 9);
            end
            tick();
        end

        // Reset in cycle 4 of a run aborts it silently.
        a = 8'h20; b = 8'h05; sub = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_outputs", {busy, done, c_out, ovf, result}, 12'h000);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done || busy) n++;
        end
        check("abort_quiet", n, 0);
        run_op(8'h12, 8'h34, 1'b0, got);
        check("after_abort", got, 10'h046);

        // Randomized back-to-back sweep against the reference model.
        begin
            logic [9:0]  q[$];
            int unsigned accepted = 0;
            int unsigned dones = 0;
            for (int c = 0; c < 9600 && (accepted < 1000 || q.size() > 0); c++) begin
                tick();
                if (done) begin
                    dones++;
                    if (q.size() == 0) check("rand_spurious_done", 1, 0);
                    else begin
                        exp = q.pop_front();
                        check("rand_result", {c_out, ovf, result}, exp);
                    end
                end
                if (!busy && accepted < 1000) begin
                    a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
                    start = 1'b1;
                    q.push_back(model(a, b, sub));
                    accepted++;
                end else if (busy) begin
                    start = 1'($urandom);
                    a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
                end else begin
                    start = 1'b0;
                end
            end
            start = 1'b0;
            check("rand_drain", q.size(), 0);
            check("rand_done_count", dones, accepted);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
